// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, LSB-first data, optional parity, stop bit.
// One serial bit per clk edge; TX_OUT and Busy are registered.
module uart_tx_frame #(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             RST,
   input  logic [width-1:0] P_DATA,
   input  logic             Data_Valid,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic             TX_OUT,
   output logic             Busy
);

   localparam int CNT_W = (width > 1) ? $clog2(width) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(width - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Must match the receiver's checker: even -> XOR, odd -> XNOR of the data.
   function automatic logic parity_bit(input logic [width-1:0] d, input logic odd);
      return odd ? ~^d : ^d;
   endfunction

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [width-1:0]   data_q;
   logic               pen_q;
   logic               par_q;
   logic               load;
   logic               tx_nxt;
   logic               busy_nxt;

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state  <= IDLE;
         cnt    <= '0;
         data_q <= '0;
         pen_q  <= 1'b0;
         par_q  <= 1'b0;
         TX_OUT <= 1'b1;
         Busy   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         if (load) begin
            data_q <= P_DATA;
            pen_q  <= PAR_EN;
            par_q  <= parity_bit(P_DATA, PAR_TYP);
         end
         TX_OUT <= tx_nxt;
         Busy   <= busy_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (Data_Valid) begin
               state_nxt = START;
               load      = 1'b1;
            end
         end
         START: begin
            state_nxt = DATA;
            cnt_nxt   = '0;
         end
         DATA: begin
            if (cnt == LAST_BIT) begin
               state_nxt = pen_q ? PARITY : STOP;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         PARITY:  state_nxt = STOP;
         STOP:    state_nxt = IDLE;
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it.
   always_comb begin
      tx_nxt   = 1'b1;
      busy_nxt = 1'b0;
      case (state_nxt)
         START: begin
            tx_nxt   = 1'b0;
            busy_nxt = 1'b1;
         end
         DATA: begin
            tx_nxt   = data_q[cnt_nxt];
            busy_nxt = 1'b1;
         end
         PARITY: begin
            tx_nxt   = par_q;
            busy_nxt = 1'b1;
         end
         STOP: begin
            tx_nxt   = 1'b1;
            busy_nxt = 1'b1;
         end
         default: begin
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: queue-based frame model checked every cycle,
// plus literal frame sequences and a loopback parity check over all words.
module tb_uart_tx_frame;

   logic       clk;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       Busy;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   uart_tx_frame #(.width(8)) dut (
      .clk        (clk),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the frame is a queue of line levels; one level per edge.
   bit m_q[$];
   bit m_tx   = 1'b1;
   bit m_busy = 1'b0;

   always @(posedge clk or negedge RST) begin
      if (!RST) begin
         m_q.delete();
         m_tx   = 1'b1;
         m_busy = 1'b0;
      end else if (m_q.size() > 0) begin
         m_tx   = m_q.pop_front();
         m_busy = 1'b1;
      end else if (!m_busy && Data_Valid) begin
         int ones;
         ones = 0;
         for (int i = 0; i < 8; i++) begin
            m_q.push_back(P_DATA[i]);
            ones += int'(P_DATA[i]);
         end
         if (PAR_EN) m_q.push_back(PAR_TYP ? (ones % 2 == 0) : (ones % 2 == 1));
         m_q.push_back(1'b1);
         m_tx   = 1'b0;
         m_busy = 1'b1;
      end else begin
         m_tx   = 1'b1;
         m_busy = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_tx", {31'd0, TX_OUT}, {31'd0, m_tx});
         check("model_busy", {31'd0, Busy}, {31'd0, m_busy});
      end
   end

   // Sends one frame from an idle line and records 12 cycles of TX_OUT.
   task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            output logic [0:11] got, output int nb);
      P_DATA     = d;
      PAR_EN     = pen;
      PAR_TYP    = ptyp;
      Data_Valid = 1'b1;
      @(posedge clk);
      #2;
      Data_Valid = 1'b0;
      P_DATA     = ~d;
      PAR_EN     = ~pen;
      PAR_TYP    = ~ptyp;
      got        = '1;
      nb         = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         got[i] = TX_OUT;
         if (Busy) nb++;
      end
      @(posedge clk);
      #2;
   endtask

   logic [0:11] got;
   int          nb;
   logic [7:0]  rd;
   logic        par_err;

   initial begin
      RST        = 1'b0;
      Data_Valid = 1'b1;
      P_DATA     = 8'hFF;
      PAR_EN     = 1'b1;
      PAR_TYP    = 1'b0;
      chk_en     = 1'b1;

      // Reset held with a strobe present: line must stay idle
      repeat (4) @(posedge clk);
      #2;
      check("rst_tx", {31'd0, TX_OUT}, 32'd1);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      Data_Valid = 1'b0;
      RST        = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      check("post_rst_idle_tx", {31'd0, TX_OUT}, 32'd1);
      check("post_rst_idle_busy", {31'd0, Busy}, 32'd0);

      run_frame(8'hA5, 1'b1, 1'b0, got, nb);
      check("a5_even_seq", {20'd0, got}, {20'd0, 12'b010100101011});
      check("a5_even_busy", nb, 11);
      run_frame(8'hA5, 1'b1, 1'b1, got, nb);
      check("a5_odd_seq", {20'd0, got}, {20'd0, 12'b010100101111});
      run_frame(8'h01, 1'b1, 1'b1, got, nb);
      check("01_odd_seq", {20'd0, got}, {20'd0, 12'b010000000011});
      run_frame(8'h3C, 1'b0, 1'b0, got, nb);
      check("3c_nopar_seq", {20'd0, got}, {20'd0, 12'b000111100111});
      check("3c_nopar_busy", nb, 10);

      // Strobes with 0xFF during START..STOP of a 0x55 frame are dropped
      P_DATA     = 8'h55;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;
      Data_Valid = 1'b1;
      @(posedge clk);
      #2;
      P_DATA = 8'hFF;
      PAR_EN = 1'b1;
      got    = '1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         got[i] = TX_OUT;
         @(posedge clk);
      end
      #2;
      Data_Valid = 1'b0;
      check("busy_drop_seq", {20'd0, got}, {20'd0, 12'b010101010111});
      @(negedge clk);
      check("busy_drop_idle_busy", {31'd0, Busy}, 32'd0);
      check("busy_drop_idle_tx", {31'd0, TX_OUT}, 32'd1);
      @(posedge clk);
      #2;
      run_frame(8'hC3, 1'b0, 1'b0, got, nb);
      check("next_frame_seq", {20'd0, got}, {20'd0, 12'b011000011111});

      // Asynchronous reset during data bit 3 of 0x00
      P_DATA     = 8'h00;
      PAR_EN     = 1'b0;
      Data_Valid = 1'b1;
      @(posedge clk);
      #2;
      Data_Valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check("mid_bit3_tx", {31'd0, TX_OUT}, 32'd0);
      check("mid_bit3_busy", {31'd0, Busy}, 32'd1);
      RST = 1'b0;
      #1;
      check("mid_rst_tx", {31'd0, TX_OUT}, 32'd1);
      check("mid_rst_busy", {31'd0, Busy}, 32'd0);
      @(posedge clk);
      #2;
      RST = 1'b1;
      repeat (14) @(posedge clk);
      #2;
      check("mid_rst_no_resume", {31'd0, TX_OUT}, 32'd1);

      // Loopback into a receiver-style parity checker, both parity types
      for (int pt = 0; pt < 2; pt++) begin
         for (int d = 0; d < 256; d++) begin
            run_frame(8'(d), 1'b1, 1'(pt), got, nb);
            for (int i = 0; i < 8; i++) rd[i] = got[1 + i];
            par_err = (pt == 1) ? (got[9] != ~^rd) : (got[9] != ^rd);
            check("loop_par_err", {31'd0, par_err}, 32'd0);
            check("loop_data", {24'd0, rd}, d);
         end
      end

      // Random traffic: inputs change every cycle, strobes land anywhere
      for (int c = 0; c < 3000; c++) begin
         P_DATA     = 8'($urandom);
         PAR_EN     = 1'($urandom_range(0, 1));
         PAR_TYP    = 1'($urandom_range(0, 1));
         Data_Valid = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         #2;
      end
      Data_Valid = 1'b0;
      repeat (15) @(posedge clk);
      #2;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
